ps2_rx_multi: RTL and testbench
===============================

PS2_RX_MULTI -- requirements
Module: ps2_rx_multi

Interface
REQ-001 Parameter NCH, 2, number of independent PS/2 receive channels (1..4; ch0 keyboard, ch1 mouse).
REQ-002 Parameter DEPTH, 16, per-channel FIFO depth in bytes (power of two, 2..256).
REQ-003 Parameter FILT, 8, clk cycles a synchronised PS/2 clock level must hold before it is accepted.
REQ-004 Parameter TIMEOUT_CYC, 200000, idle clk cycles after which a partial frame is aborted (used only with PS2_RX_TIMEOUT_EN).
REQ-005 clk  in  1  system clock, 100 MHz; one clock, all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ps2_clk  in  NCH  raw PS/2 clock lines, asynchronous.
REQ-008 ps2_dat  in  NCH  raw PS/2 data lines, asynchronous.
REQ-009 sel  in  1  bus access strobe, one cycle per access.
REQ-010 wr  in  1  1 = write, 0 = read; valid with sel.
REQ-011 ch  in  2  channel index; accesses with ch >= NCH read 0x00 and are otherwise ignored.
REQ-012 addr  in  1  0 = DATA, 1 = STATUS/CTRL.
REQ-013 wdata  in  8  write data.
REQ-014 rdata  out  8  read data, registered.
REQ-015 irq  out  NCH  per-channel level interrupt: FIFO not empty and enabled.

Function
REQ-016 Each ps2_clk/ps2_dat SHALL pass a 2-FF synchroniser; ps2_clk SHALL then pass a FILT-cycle stability filter; a frame bit SHALL be sampled from synchronised ps2_dat on each filtered 1->0 transition.
REQ-017 Per-channel FSM SHALL be IDLE -> START -> DATA(8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing one state (or one DATA bit) per sampled edge.
REQ-018 In IDLE a sampled start bit of 1 SHALL set STATUS.FERR and remain in IDLE; nothing is pushed.
REQ-019 Parity SHALL be odd over 8 data bits + parity bit; mismatch SHALL set STATUS.PERR and discard the byte.
REQ-020 Stop bit of 0 SHALL set STATUS.FERR and discard the byte.
REQ-021 A valid byte SHALL be pushed into the channel FIFO on the clk cycle after the stop-bit sample.
REQ-022 Push into a full FIFO SHALL drop the new byte and set STATUS.OVF; FIFO contents unchanged.
REQ-023 Read of DATA SHALL return the FIFO head on rdata one cycle after sel and pop it; read when empty SHALL return 0x00 with no pointer change.
REQ-024 Simultaneous push and pop on the same cycle SHALL both occur; count unchanged; a full FIFO accepts the push in this case.
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 STATUS read: bit0 NE, bit1 OVF, bit2 PERR, bit3 FERR, bit4 TO, bit7 EN, others 0; reading has no side effects.
REQ-027 CTRL write: bit0 = 1 flushes FIFO and clears OVF/PERR/FERR/TO and aborts any partial frame to IDLE; bit7 sets EN; other bits ignored.
REQ-028 With EN = 0 the channel FSM SHALL hold IDLE and ignore edges; irq forced 0.
REQ-029 Writes to DATA SHALL be ignored.

Reset
REQ-030 On reset: all FSMs IDLE, FIFOs empty, all status bits 0, EN = 1, rdata = 0x00, irq = 0, filters assume line high.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no push and no error flag.

Configuration
REQ-032 Macro PS2_RX_TIMEOUT_EN defined: per-channel counter reset on every sampled edge; reaching TIMEOUT_CYC outside IDLE SHALL abort to IDLE and set STATUS.TO.
REQ-033 PS2_RX_TIMEOUT_EN undefined: no counter logic; STATUS.TO reads 0; partial frames persist until completed, flushed or reset.

Structure
REQ-034 Package ps2_rx_pkg SHALL hold the FSM state enum, STATUS bit index constants, CTRL bit constants and register address constants.
REQ-035 Sub-module ps2_rx_chan (sync, filter, FSM, FIFO, flags for one channel) SHALL be instantiated NCH times via generate; the top SHALL hold only the register decode and rdata mux.

Verification
REQ-036 Send 0xAA then 0xBB on ch0 (start 0, odd parity, stop 1) -> DATA reads return 0xAA then 0xBB, then STATUS.NE = 0, irq[0] 1 then 0.
REQ-037 Send 0xAA with start bit 1 on ch0 -> STATUS = 0x88 (FERR, EN), FIFO empty; then write CTRL 0x81, send 0xCC, 0xDD -> read 0xCC, STATUS = 0x81.
REQ-038 Send 0x55 with inverted parity -> PERR set, nothing pushed; next valid 0x12 -> read 0x12.
REQ-039 DEPTH = 4: send 5 bytes 0x01..0x05 -> OVF set, reads return 0x01..0x04, fifth read 0x00; pop coinciding with push at full -> no loss, count stays 4.
REQ-040 Interleaved frames on ch0 (0x1C) and ch1 (0xFA) -> each channel returns its own byte; ch=3 read returns 0x00.
REQ-041 PS2_RX_TIMEOUT_EN, TIMEOUT_CYC = 1000: stop ps2_clk after 4 data bits -> TO set after 1000 cycles, FSM IDLE, next full frame 0x33 received correctly.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg -- shared definitions for the multi-channel PS/2 receiver.
//   * receive FSM state encoding
//   * STATUS register bit positions
//   * CTRL register bit positions
//   * register address decode values
//   * odd-parity helper
// Optional feature macro used by the design: PS2_RX_TIMEOUT_EN.
package ps2_rx_pkg;

  // The state names the bit the next sampled edge delivers:
  //   IDLE -> start bit, START -> data bit 0, DATA -> data bits 1..7,
  //   PARITY -> parity bit, STOP -> stop bit.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } ps2_state_t;

  // STATUS bit positions
  localparam int STAT_NE   = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_PERR = 2;
  localparam int STAT_FERR = 3;
  localparam int STAT_TO   = 4;
  localparam int STAT_EN   = 7;

  // CTRL bit positions
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_EN    = 7;

  // Register addresses
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;
  localparam logic ADDR_CTRL   = 1'b1;

  // True when data plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_multi_chan.sv
// ps2_rx_chan -- one PS/2 receive channel.
// Synchronises and filters the PS/2 clock, decodes 11-bit frames, queues good
// bytes in a DEPTH-entry FIFO and keeps the sticky status flags.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   i_ps2_clk/i_ps2_dat raw asynchronous PS/2 lines
//   i_pop             pop the FIFO head (ignored when empty)
//   i_ctrl_we         CTRL write strobe, i_ctrl_flush / i_ctrl_en its bits
//   o_head            current FIFO head (0x00 when empty)
//   o_status          STATUS register image
//   o_irq             FIFO not empty and channel enabled
// Optional: PS2_RX_TIMEOUT_EN adds an idle-frame timeout (STATUS.TO).
module ps2_rx_chan
  import ps2_rx_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FILT        = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  input  logic       i_pop,
  input  logic       i_ctrl_we,
  input  logic       i_ctrl_flush,
  input  logic       i_ctrl_en,
  output logic [7:0] o_head,
  output logic [7:0] o_status,
  output logic       o_irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;

  // ---------------- synchronisers (idle line is high) ----------------
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // ---------------- clock stability filter ----------------
  // A new level is accepted only after it differs from the filtered level for
  // FILT consecutive cycles; any return to the old level restarts the count.
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          w_filt_hit;
  logic          w_fall;

  assign w_filt_hit = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == FW'(FILT - 1));
  assign w_fall     = w_filt_hit && r_clk_filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_hit) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FW'(1);
    end
  end

  // ---------------- control / flags ----------------
  logic r_en, r_ovf, r_perr, r_ferr;
  logic w_flush, w_edge, w_timeout, w_to_flag;

  assign w_flush = i_ctrl_we && i_ctrl_flush;
  assign w_edge  = w_fall && r_en;

  // ---------------- receive FSM ----------------
  ps2_state_t r_state, w_state_next;
  logic [7:0] r_shift, w_shift_next;
  logic [2:0] r_bitcnt, w_bitcnt_next;
  logic       r_bad_par, w_bad_par_next;
  logic       w_set_ferr, w_set_perr, w_push_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'h00;
      r_bitcnt  <= 3'd0;
      r_bad_par <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bitcnt  <= w_bitcnt_next;
      r_bad_par <= w_bad_par_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bitcnt_next  = r_bitcnt;
    w_bad_par_next = r_bad_par;
    w_set_ferr     = 1'b0;
    w_set_perr     = 1'b0;
    w_push_req     = 1'b0;
    if (w_edge) begin
      case (r_state)
        ST_IDLE: begin
          if (r_dat_s2) w_set_ferr = 1'b1;
          else          w_state_next = ST_START;
        end
        ST_START: begin
          w_shift_next  = {r_dat_s2, r_shift[7:1]};
          w_bitcnt_next = 3'd1;
          w_state_next  = ST_DATA;
        end
        ST_DATA: begin
          w_shift_next  = {r_dat_s2, r_shift[7:1]};
          w_bitcnt_next = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_next = ST_PARITY;
        end
        ST_PARITY: begin
          // Keep receiving after a bad parity so the stop bit is not
          // mistaken for the start of a new frame.
          w_bad_par_next = !odd_parity_ok(r_shift, r_dat_s2);
          w_set_perr     = w_bad_par_next;
          w_state_next   = ST_STOP;
        end
        ST_STOP: begin
          if (!r_dat_s2)      w_set_ferr = 1'b1;
          else if (!r_bad_par) w_push_req = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
    // Flush, disable and timeout all abandon any partial frame.
    if (w_flush || !r_en || w_timeout) begin
      w_state_next  = ST_IDLE;
      w_bitcnt_next = 3'd0;
      w_push_req    = 1'b0;
    end
  end

  // ---------------- optional frame timeout ----------------
`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_to;

  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_to_flag = r_to;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_to     <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_edge || w_timeout) r_to_cnt <= '0;
      else                                           r_to_cnt <= r_to_cnt + TW'(1);
      if (w_flush)        r_to <= 1'b0;
      else if (w_timeout) r_to <= 1'b1;
    end
  end
`else
  localparam int to_cyc_unused = TIMEOUT_CYC;
  assign w_timeout = 1'b0;
  assign w_to_flag = 1'b0;
`endif

  // ---------------- push stage ----------------
  // The byte is handed to the FIFO one cycle after the stop-bit sample.
  logic       r_push;
  logic [7:0] r_push_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
    end else begin
      r_push <= w_push_req;
      if (w_push_req) r_push_data <= r_shift;
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_ne, w_pop_ok, w_push_ok, w_ovf;

  assign w_ne      = (r_count != '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop && w_ne;
  // A full FIFO still takes the byte when a pop frees a slot the same cycle.
  assign w_push_ok = r_push && (!w_full || w_pop_ok);
  assign w_ovf     = r_push && w_full && !w_pop_ok;

  always_ff @(posedge clk) begin
    if (w_push_ok && !w_flush) r_mem[r_wptr] <= r_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= 1'b1;
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (i_ctrl_we) r_en <= i_ctrl_en;
      if (w_flush) begin
        r_ovf  <= 1'b0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end else begin
        if (w_ovf)      r_ovf  <= 1'b1;
        if (w_set_perr) r_perr <= 1'b1;
        if (w_set_ferr) r_ferr <= 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
  assign o_head = w_ne ? r_mem[r_rptr] : 8'h00;
  assign o_irq  = w_ne && r_en;

  always_comb begin
    o_status            = 8'h00;
    o_status[STAT_NE]   = w_ne;
    o_status[STAT_OVF]  = r_ovf;
    o_status[STAT_PERR] = r_perr;
    o_status[STAT_FERR] = r_ferr;
    o_status[STAT_TO]   = w_to_flag;
    o_status[STAT_EN]   = r_en;
  end

endmodule

// File: rtl/ps2_rx_multi.sv
// ps2_rx_multi -- NCH independent PS/2 receivers behind a small register bus.
// Ports:
//   clk, reset        100 MHz system clock, synchronous active-high reset
//   ps2_clk, ps2_dat  raw PS/2 lines, one bit per channel
//   sel, wr, ch, addr single-cycle bus access (addr 0 DATA, 1 STATUS/CTRL)
//   wdata             write data (CTRL: bit0 flush, bit7 enable)
//   rdata             registered read data, valid the cycle after sel
//   irq               per-channel level interrupt
// Optional: PS2_RX_TIMEOUT_EN enables the per-channel frame timeout.
module ps2_rx_multi
  import ps2_rx_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int DEPTH       = 16,
  parameter int FILT        = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] ps2_clk,
  input  logic [NCH-1:0] ps2_dat,
  input  logic           sel,
  input  logic           wr,
  input  logic [1:0]     ch,
  input  logic           addr,
  input  logic [7:0]     wdata,
  output logic [7:0]     rdata,
  output logic [NCH-1:0] irq
);

  logic [7:0] w_head   [NCH];
  logic [7:0] w_status [NCH];
  logic [7:0] w_rdata_next;
  logic       w_unused_wdata;

  assign w_unused_wdata = ^wdata[6:1];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic w_hit;
    assign w_hit = sel && (ch == 2'(gi));

    ps2_rx_chan #(
      .DEPTH       (DEPTH),
      .FILT        (FILT),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .i_ps2_clk    (ps2_clk[gi]),
      .i_ps2_dat    (ps2_dat[gi]),
      .i_pop        (w_hit && !wr && (addr == ADDR_DATA)),
      .i_ctrl_we    (w_hit && wr && (addr == ADDR_CTRL)),
      .i_ctrl_flush (wdata[CTRL_FLUSH]),
      .i_ctrl_en    (wdata[CTRL_EN]),
      .o_head       (w_head[gi]),
      .o_status     (w_status[gi]),
      .o_irq        (irq[gi])
    );
  end

  // Channels that do not exist fall through to 0x00.
  always_comb begin
    w_rdata_next = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 2'(i)) w_rdata_next = (addr == ADDR_STATUS) ? w_status[i] : w_head[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)            rdata <= 8'h00;
    else if (sel && !wr)  rdata <= w_rdata_next;
  end

endmodule

// File: tb/tb_ps2_rx_multi.sv
// Directed bench for ps2_rx_multi (NCH=2, DEPTH=4, FILT=8, TIMEOUT_CYC=1000).
module tb_ps2_rx_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ps2_clk, ps2_dat;
  logic       sel, wr, addr;
  logic [1:0] ch;
  logic [7:0] wdata, rdata;
  logic [1:0] irq;
  logic [7:0] rd, popped;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ps2_rx_multi #(.NCH(2), .DEPTH(4), .FILT(8), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .sel(sel), .wr(wr), .ch(ch), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] c, input logic a, output logic [7:0] d);
    @(negedge clk); sel = 1'b1; wr = 1'b0; ch = c; addr = a;
    @(negedge clk); sel = 1'b0; d = rdata;
    $display("rd  ch%0d addr%0d -> 0x%02h", c, a, d);
  endtask

  task automatic read_check(input string tag, input logic [1:0] c, input logic a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(c, a, d);
    check(tag, d, exp);
  endtask

  task automatic bus_write(input logic [1:0] c, input logic a, input logic [7:0] d);
    @(negedge clk); sel = 1'b1; wr = 1'b1; ch = c; addr = a; wdata = d;
    @(negedge clk); sel = 1'b0; wr = 1'b0;
    $display("wr  ch%0d addr%0d <- 0x%02h", c, a, d);
  endtask

  // Sends the first nbits of a frame. With pop_mid a DATA read is issued so
  // that it lands on the same cycle as the push of this frame's byte
  // (2 sync stages + FILT filter cycles, then one cycle to the push).
  task automatic send_frame(input logic [1:0] c, input logic [7:0] b, input logic start,
                            input logic flip, input logic stop, input int nbits,
                            input logic pop_mid, output logic [7:0] pd);
    logic [10:0] f;
    f = {stop, (~^b) ^ flip, b, start};
    pd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      ps2_dat[c] = f[i];
      repeat (10) @(negedge clk);
      ps2_clk[c] = 1'b0;
      if (i == 10 && pop_mid) begin
        repeat (10) @(negedge clk);
        sel = 1'b1; wr = 1'b0; ch = c; addr = 1'b0;
        @(negedge clk);
        sel = 1'b0; pd = rdata;
        repeat (9) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      ps2_clk[c] = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_dat[c] = 1'b1;
    $display("tx  ch%0d byte 0x%02h (%0d bits)", c, b, nbits);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] b);
    logic [7:0] d;
    send_frame(c, b, 1'b0, 1'b0, 1'b1, 11, 1'b0, d);
  endtask

  // Two valid frames with ch1's clock lagging ch0's by five cycles.
  task automatic send_two(input logic [7:0] b0, input logic [7:0] b1);
    logic [10:0] f0, f1;
    f0 = {1'b1, ~^b0, b0, 1'b0};
    f1 = {1'b1, ~^b1, b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = {f1[i], f0[i]};
      repeat (5) @(negedge clk);  ps2_clk[0] = 1'b0;
      repeat (5) @(negedge clk);  ps2_clk[1] = 1'b0;
      repeat (15) @(negedge clk); ps2_clk[0] = 1'b1;
      repeat (5) @(negedge clk);  ps2_clk[1] = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_dat = 2'b11;
    $display("tx  ch0 0x%02h / ch1 0x%02h interleaved", b0, b1);
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 2'b11; ps2_dat = 2'b11;
    sel = 1'b0; wr = 1'b0; ch = 2'd0; addr = 1'b0; wdata = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_rdata", rdata, 8'h00);
    check("rst_irq", {6'b0, irq}, 8'h00);
    read_check("rst_stat0", 2'd0, 1'b1, 8'h80);
    read_check("rst_stat1", 2'd1, 1'b1, 8'h80);
    read_check("rst_empty", 2'd0, 1'b0, 8'h00);

    // Two good bytes on ch0
    send(2'd0, 8'hAA);
    send(2'd0, 8'hBB);
    check("irq_ne", {6'b0, irq}, 8'h01);
    read_check("rd_aa", 2'd0, 1'b0, 8'hAA);
    check("irq_one_left", {6'b0, irq}, 8'h01);
    read_check("rd_bb", 2'd0, 1'b0, 8'hBB);
    check("irq_empty", {6'b0, irq}, 8'h00);
    read_check("stat_empty", 2'd0, 1'b1, 8'h80);

    // Start bit 1; parity slot chosen so the realigned tail is parity-clean.
    send_frame(2'd0, 8'hAA, 1'b1, 1'b1, 1'b1, 11, 1'b0, popped);
    read_check("stat_ferr", 2'd0, 1'b1, 8'h88);
    check("irq_ferr", {6'b0, irq}, 8'h00);
    bus_write(2'd0, 1'b1, 8'h81);
    read_check("stat_flushed", 2'd0, 1'b1, 8'h80);
    send(2'd0, 8'hCC);
    send(2'd0, 8'hDD);
    read_check("rd_cc", 2'd0, 1'b0, 8'hCC);
    read_check("stat_81", 2'd0, 1'b1, 8'h81);
    read_check("rd_dd", 2'd0, 1'b0, 8'hDD);

    // Parity error
    send_frame(2'd0, 8'h55, 1'b0, 1'b1, 1'b1, 11, 1'b0, popped);
    read_check("stat_perr", 2'd0, 1'b1, 8'h84);
    send(2'd0, 8'h12);
    read_check("rd_12", 2'd0, 1'b0, 8'h12);
    bus_write(2'd0, 1'b1, 8'h81);
    read_check("stat_perr_clr", 2'd0, 1'b1, 8'h80);

    // Overflow at DEPTH=4
    for (int i = 1; i <= 5; i++) send(2'd0, 8'(i));
    read_check("stat_ovf", 2'd0, 1'b1, 8'h83);
    read_check("ovf_rd1", 2'd0, 1'b0, 8'h01);
    read_check("ovf_rd2", 2'd0, 1'b0, 8'h02);
    read_check("ovf_rd3", 2'd0, 1'b0, 8'h03);
    read_check("ovf_rd4", 2'd0, 1'b0, 8'h04);
    read_check("ovf_rd5", 2'd0, 1'b0, 8'h00);
    bus_write(2'd0, 1'b1, 8'h81);

    // Pop coinciding with push into a full FIFO
    for (int i = 0; i < 4; i++) send(2'd0, 8'h11 + 8'(i));
    send_frame(2'd0, 8'h15, 1'b0, 1'b0, 1'b1, 11, 1'b1, popped);
    check("pop_at_push", popped, 8'h11);
    read_check("stat_no_ovf", 2'd0, 1'b1, 8'h81);
    read_check("full_rd12", 2'd0, 1'b0, 8'h12);
    read_check("full_rd13", 2'd0, 1'b0, 8'h13);
    read_check("full_rd14", 2'd0, 1'b0, 8'h14);
    read_check("full_rd15", 2'd0, 1'b0, 8'h15);
    read_check("full_drained", 2'd0, 1'b1, 8'h80);

    // Interleaved channels and out-of-range channel
    send_two(8'h1C, 8'hFA);
    check("irq_both", {6'b0, irq}, 8'h03);
    read_check("rd_ch0_1c", 2'd0, 1'b0, 8'h1C);
    read_check("rd_ch1_fa", 2'd1, 1'b0, 8'hFA);
    read_check("rd_ch3_data", 2'd3, 1'b0, 8'h00);
    read_check("rd_ch2_stat", 2'd2, 1'b1, 8'h00);
    read_check("stat_ch1", 2'd1, 1'b1, 8'h80);

    // Disable: irq masked, edges ignored, FIFO kept
    send(2'd0, 8'h77);
    bus_write(2'd0, 1'b1, 8'h00);
    check("irq_dis", {6'b0, irq}, 8'h00);
    read_check("stat_dis", 2'd0, 1'b1, 8'h01);
    send(2'd0, 8'h66);
    read_check("stat_dis_rx", 2'd0, 1'b1, 8'h01);
    bus_write(2'd0, 1'b1, 8'h80);
    check("irq_reen", {6'b0, irq}, 8'h01);
    read_check("rd_77", 2'd0, 1'b0, 8'h77);
    read_check("rd_after_77", 2'd0, 1'b0, 8'h00);

    // Writes to DATA are ignored
    bus_write(2'd0, 1'b0, 8'h5A);
    read_check("wr_data_ign", 2'd0, 1'b0, 8'h00);

    // Reset mid-frame
    send_frame(2'd0, 8'h3C, 1'b0, 1'b0, 1'b1, 5, 1'b0, popped);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midrst_rdata", rdata, 8'h00);
    read_check("midrst_stat", 2'd0, 1'b1, 8'h80);
    send(2'd0, 8'h3C);
    read_check("midrst_rd", 2'd0, 1'b0, 8'h3C);

    // Stalled frame: start + 4 data bits, then the clock stops
    send_frame(2'd0, 8'h33, 1'b0, 1'b0, 1'b1, 5, 1'b0, popped);
    repeat (1200) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    read_check("stat_to", 2'd0, 1'b1, 8'h90);
    send(2'd0, 8'h33);
    read_check("to_rd_33", 2'd0, 1'b0, 8'h33);
    bus_write(2'd0, 1'b1, 8'h81);
    read_check("to_clr", 2'd0, 1'b1, 8'h80);
`else
    read_check("stat_no_to", 2'd0, 1'b1, 8'h80);
    bus_write(2'd0, 1'b1, 8'h81);
    send(2'd0, 8'h33);
    read_check("rd_33", 2'd0, 1'b0, 8'h33);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
